hazard_unit: RTL

Stall and forwarding controller for the five-stage MIPS pipeline (F/D/E/M/W). Decodes the D-stage instruction into its class and its source and destination registers. Keeps its own shadow of the E, M and W stages: destination register, remaining result latency (Tnew), and whether the instruction starts a mult/div. From these it generates the F/D freeze, the E bubble, the forwarding selects, and a multi-cycle mult/div busy interlock. It replaces the purely combinational class decode with a registered, parametrised hazard engine.

---
 rtl/hazard_pkg.sv | 114 +++++++++++
 rtl/hazard_unit_if.sv | 21 ++
 rtl/hazard_unit_instr_class.sv | 146 ++++++++++++++
 rtl/hazard_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types, timing constants and helpers for the MIPS hazard engine.
package hazard_pkg;

  typedef struct packed {
    logic b;
    logic cal_r;
    logic cal_i;
    logic load;
    logic store;
    logic jal;
    logic jr;
    logic jalr;
    logic mf;
    logic mdft;
  } iclass_t;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MADDU = 6'h01;
  localparam logic [5:0] FN_MSUB  = 6'h04;
  localparam logic [5:0] FN_MSUBU = 6'h05;

  typedef struct packed {
    logic [4:0] dest;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md_start;
    logic       is_div;
  } stage_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic stage_t advance(input stage_t s);
    stage_t n;
    n      = s;
    n.tnew = tnew_dec(s.tnew);
    return n;
  endfunction

  function automatic logic src_hit(input logic [4:0] src, input stage_t s);
    return (src != 5'd0) && (src == s.dest);
  endfunction

  // Without forwarding any match interlocks; with it only a late result does.
  function automatic logic stall_hit(input logic [4:0] src, input logic [1:0] tuse,
                                     input stage_t s, input logic fwd_en);
    return src_hit(src, s) && (!fwd_en || (s.tnew > tuse));
  endfunction

  // The youngest matching stage owns the value; it is forwarded only once ready.
  function automatic logic [1:0] fwd_pick(input logic [4:0] src, input logic use_e,
                                          input stage_t e, input stage_t m, input stage_t w);
    if (use_e && src_hit(src, e)) begin
      return (e.tnew == 2'd0) ? FWD_E : FWD_RF;
    end else if (src_hit(src, m)) begin
      return (m.tnew == 2'd0) ? FWD_M : FWD_RF;
    end else if (src_hit(src, w)) begin
      return (w.tnew == 2'd0) ? FWD_W : FWD_RF;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle of the hazard unit.
interface hazard_unit_if;
  logic [31:0] ir_d;
  logic        freeze;
  logic        stall;
  logic        md_busy;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;

  modport master (
    output ir_d, freeze,
    input  stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
  );

  modport slave (
    input  ir_d, freeze,
    output stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
  );
endinterface

// File: rtl/hazard_unit_instr_class.sv
// Combinational MIPS decoder: class, destination, read registers, Tuse/Tnew, mult/div flags.
module instr_class
  import hazard_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     cls,
  output logic [4:0]  dest,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew,
  output logic        md_start,
  output logic        is_div
);

  logic [5:0] op_s;
  logic [5:0] fn_s;
  logic [4:0] rs_f_s;
  logic [4:0] rt_f_s;
  logic [4:0] rd_f_s;
  logic       md_op_s;
  logic       mt_op_s;
  logic       no_dest_s;
  logic       unused_s;

  assign op_s      = ir[31:26];
  assign rs_f_s    = ir[25:21];
  assign rt_f_s    = ir[20:16];
  assign rd_f_s    = ir[15:11];
  assign fn_s      = ir[5:0];
  assign unused_s  = ^ir[10:6];
  assign md_start  = md_op_s;
  assign no_dest_s = md_op_s | mt_op_s;

  // Class split; mult/div-unit users are CAL_R or MF and additionally MDFT.
  always_comb begin
    cls     = '0;
    md_op_s = 1'b0;
    mt_op_s = 1'b0;
    is_div  = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        case (fn_s)
          FN_JR:   cls.jr   = 1'b1;
          FN_JALR: cls.jalr = 1'b1;
          FN_MFHI, FN_MFLO: begin
            cls.mf   = 1'b1;
            cls.mdft = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            cls.cal_r = 1'b1;
            cls.mdft  = 1'b1;
            mt_op_s   = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            cls.cal_r = 1'b1;
            cls.mdft  = 1'b1;
            md_op_s   = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            cls.cal_r = 1'b1;
            cls.mdft  = 1'b1;
            md_op_s   = 1'b1;
            is_div    = 1'b1;
          end
          default: cls.cal_r = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        case (fn_s)
          FN_MADD, FN_MADDU, FN_MSUB, FN_MSUBU: begin
            cls.cal_r = 1'b1;
            cls.mdft  = 1'b1;
            md_op_s   = 1'b1;
          end
          default: cls = '0;
        endcase
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ:                        cls.jr    = 1'b1;
      OP_BEQ, OP_BNE:                                     cls.b     = 1'b1;
      OP_JAL:                                             cls.jal   = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:                   cls.cal_i = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:                cls.load  = 1'b1;
      OP_SB, OP_SH, OP_SW:                                cls.store = 1'b1;
      default:                                            cls       = '0;
    endcase
  end

  // Register usage and timing; a register that is not read is reported as 0.
  always_comb begin
    dest    = 5'd0;
    tnew    = TNEW_LINK;
    rs      = 5'd0;
    rt      = 5'd0;
    tuse_rs = TUSE_1;
    tuse_rt = TUSE_2;

    if (cls.cal_r && !no_dest_s) begin
      dest = rd_f_s;
      tnew = TNEW_ALU;
    end else if (cls.mf) begin
      dest = rd_f_s;
      tnew = TNEW_ALU;
    end else if (cls.jalr) begin
      dest = rd_f_s;
      tnew = TNEW_LINK;
    end else if (cls.cal_i || cls.load) begin
      dest = rt_f_s;
      tnew = cls.load ? TNEW_LOAD : TNEW_ALU;
    end else if (cls.jal) begin
      dest = 5'd31;
      tnew = TNEW_LINK;
    end else begin
      dest = 5'd0;
      tnew = TNEW_LINK;
    end

    if (cls.b || cls.jr || cls.jalr) begin
      rs      = rs_f_s;
      tuse_rs = TUSE_0;
    end else if (cls.cal_r || cls.cal_i || cls.load || cls.store || cls.mdft) begin
      rs      = rs_f_s;
      tuse_rs = TUSE_1;
    end else begin
      rs      = 5'd0;
      tuse_rs = TUSE_1;
    end

    if (cls.b) begin
      rt      = rt_f_s;
      tuse_rt = TUSE_0;
    end else if (cls.cal_r) begin
      rt      = rt_f_s;
      tuse_rt = TUSE_1;
    end else if (cls.store) begin
      rt      = rt_f_s;
      tuse_rt = TUSE_2;
    end else begin
      rt      = 5'd0;
      tuse_rt = TUSE_2;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Registered stall/forwarding engine for the five-stage MIPS pipeline.
// Build macro HAZARD_FWD_EN enables forwarding; without it any E/M source match interlocks.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset_n,
  hazard_unit_if.slave hz
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

`ifdef HAZARD_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  iclass_t          cls_s;
  logic [4:0]       d_dest_s;
  logic [4:0]       d_rs_s;
  logic [4:0]       d_rt_s;
  logic [1:0]       tuse_rs_s;
  logic [1:0]       tuse_rt_s;
  logic [1:0]       d_tnew_s;
  logic             d_md_s;
  logic             d_div_s;
  stage_t           d_info_s;
  stage_t           ex_next_s;
  stage_t           ex_r;
  stage_t           mem_r;
  stage_t           wb_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             data_stall_s;
  logic             md_busy_s;
  logic             stall_s;
  logic             unused_s;

  instr_class u_dec (
    .ir       (hz.ir_d),
    .cls      (cls_s),
    .dest     (d_dest_s),
    .rs       (d_rs_s),
    .rt       (d_rt_s),
    .tuse_rs  (tuse_rs_s),
    .tuse_rt  (tuse_rt_s),
    .tnew     (d_tnew_s),
    .md_start (d_md_s),
    .is_div   (d_div_s)
  );

  assign unused_s = ^{cls_s, ex_r, mem_r, wb_r};

  // D-stage decision against the shadow pipeline, plus next shadow/counter values.
  always_comb begin
    d_info_s          = '0;
    d_info_s.dest     = d_dest_s;
    d_info_s.tnew     = d_tnew_s;
    d_info_s.rs       = d_rs_s;
    d_info_s.rt       = d_rt_s;
    d_info_s.md_start = d_md_s;
    d_info_s.is_div   = d_div_s;

    data_stall_s = stall_hit(d_rs_s, tuse_rs_s, ex_r,  FWD_EN) |
                   stall_hit(d_rs_s, tuse_rs_s, mem_r, FWD_EN) |
                   stall_hit(d_rt_s, tuse_rt_s, ex_r,  FWD_EN) |
                   stall_hit(d_rt_s, tuse_rt_s, mem_r, FWD_EN);
    md_busy_s    = (cnt_r != '0) | ex_r.md_start;
    stall_s      = data_stall_s | (md_busy_s & cls_s.mdft);
    ex_next_s    = stall_s ? '0 : d_info_s;

    if (ex_r.md_start) begin
      cnt_next_s = ex_r.is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_r != '0) begin
      cnt_next_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Shadow pipeline and mult/div countdown; everything holds while frozen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
      cnt_r <= '0;
    end else if (!hz.freeze) begin
      ex_r  <= ex_next_s;
      mem_r <= advance(ex_r);
      wb_r  <= advance(mem_r);
      cnt_r <= cnt_next_s;
    end
  end

  // Outputs are held quiet while reset is low.
  always_comb begin
    hz.stall    = 1'b0;
    hz.md_busy  = 1'b0;
    hz.fwd_rs_d = FWD_RF;
    hz.fwd_rt_d = FWD_RF;
    hz.fwd_rs_e = FWD_RF;
    hz.fwd_rt_e = FWD_RF;
    if (reset_n) begin
      hz.stall   = stall_s;
      hz.md_busy = md_busy_s;
`ifdef HAZARD_FWD_EN
      hz.fwd_rs_d = fwd_pick(d_rs_s, 1'b1, ex_r, mem_r, wb_r);
      hz.fwd_rt_d = fwd_pick(d_rt_s, 1'b1, ex_r, mem_r, wb_r);
      hz.fwd_rs_e = fwd_pick(ex_r.rs, 1'b0, ex_r, mem_r, wb_r);
      hz.fwd_rt_e = fwd_pick(ex_r.rt, 1'b0, ex_r, mem_r, wb_r);
`endif
    end else begin
      hz.stall   = 1'b0;
      hz.md_busy = 1'b0;
    end
  end

endmodule
